// File: rtl/decode_stage.sv
// NanoQuarter ID stage: field split, 8x16 register file with write-through
// bypass, load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   instr_in,
    input  logic [31:0]   PC_in,
    input  logic          valid_in,
    input  logic          stall_in,
    input  logic          flush_in,
    input  logic          wb_regwrite,
    input  logic [2:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] reg1data_out,
    output logic [DW-1:0] reg2data_out,
    output logic [7:0]    jtarget_out,
    output logic [5:0]    memaddr_out,
    output logic [4:0]    boffset_out,
    output logic [2:0]    funct_out,
    output logic [2:0]    ALUfunct_out,
    output logic [1:0]    op_out,
    output logic [1:0]    shamt_out,
    output logic [2:0]    dest_out,
    output logic          bne_out,
    output logic          jr_out,
    output logic [31:0]   PC_out,
    output logic          valid_out,
    output logic          stall_out
);

    typedef struct packed {
        logic          valid;
        logic [1:0]    op;
        logic [2:0]    funct;
        logic [2:0]    aluFunct;
        logic [2:0]    dest;
        logic [DW-1:0] reg1;
        logic [DW-1:0] reg2;
        logic [7:0]    jtarget;
        logic [5:0]    memaddr;
        logic [4:0]    boffset;
        logic [1:0]    shamt;
        logic          bne;
        logic          jr;
        logic [31:0]   pc;
    } idEx_t;

    logic [DW-1:0] regs_q [NREGS];
    idEx_t         idEx_q, idEx_d, bubble, decoded;

    logic [1:0]    op;
    logic [2:0]    funct, rsAddr, rtAddr;
    logic [2:0]    aluFunct, dest;
    logic          useRs, useRt;
    logic [DW-1:0] reg1Data, reg2Data;
    logic          loadInEx, hazard;

    assign op     = instr_in[15:14];
    assign funct  = instr_in[2:0];
    assign rsAddr = instr_in[13:11];
    assign rtAddr = instr_in[10:8];

    // A writeback landing this cycle is forwarded so decode never sees stale data.
    assign reg1Data = (wb_regwrite && wb_addr == rsAddr) ? wb_data : regs_q[rsAddr];
    assign reg2Data = (wb_regwrite && wb_addr == rtAddr) ? wb_data : regs_q[rtAddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_regwrite) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        aluFunct = 3'b000;
        dest     = 3'b000;
        useRs    = 1'b0;
        useRt    = 1'b0;
        case (op)
            2'b00: begin
                aluFunct = funct;
                dest     = instr_in[7:5];
                useRs    = 1'b1;
                useRt    = 1'b1;
            end
            2'b01: begin
                aluFunct = 3'b101;
                dest     = rsAddr;
                useRs    = ~funct[0];
            end
            2'b10: begin
                useRs = (funct == 3'b000);
            end
            default: begin
                aluFunct = 3'b110;
                useRs    = 1'b1;
                useRt    = 1'b1;
            end
        endcase
    end

    // Loads have odd funct codes; only they can create a load-use hazard.
    assign loadInEx  = idEx_q.valid && (idEx_q.op == 2'b01) && idEx_q.funct[0];
    assign hazard    = (useRs && rsAddr == idEx_q.dest) || (useRt && rtAddr == idEx_q.dest);
    assign stall_out = valid_in && loadInEx && hazard;

    always_comb begin
        bubble    = '0;
        bubble.op = 2'b11;

        decoded          = '0;
        decoded.valid    = 1'b1;
        decoded.op       = op;
        decoded.funct    = funct;
        decoded.aluFunct = aluFunct;
        decoded.dest     = dest;
        decoded.reg1     = reg1Data;
        decoded.reg2     = reg2Data;
        decoded.jtarget  = instr_in[10:3];
        decoded.memaddr  = instr_in[10:5];
        decoded.boffset  = instr_in[7:3];
        decoded.shamt    = instr_in[4:3];
        decoded.bne      = (op == 2'b11) && (funct == 3'b000);
        decoded.jr       = (op == 2'b10) && (funct == 3'b000);
        decoded.pc       = PC_in;

        idEx_d = idEx_q;
        if (stall_in) begin
            idEx_d = idEx_q;
        end else if (flush_in || stall_out || !valid_in) begin
            idEx_d = bubble;
        end else begin
            idEx_d = decoded;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idEx_q <= bubble;
        end else begin
            idEx_q <= idEx_d;
        end
    end

    assign reg1data_out = idEx_q.reg1;
    assign reg2data_out = idEx_q.reg2;
    assign jtarget_out  = idEx_q.jtarget;
    assign memaddr_out  = idEx_q.memaddr;
    assign boffset_out  = idEx_q.boffset;
    assign funct_out    = idEx_q.funct;
    assign ALUfunct_out = idEx_q.aluFunct;
    assign op_out       = idEx_q.op;
    assign shamt_out    = idEx_q.shamt;
    assign dest_out     = idEx_q.dest;
    assign bne_out      = idEx_q.bne;
    assign jr_out       = idEx_q.jr;
    assign PC_out       = idEx_q.pc;
    assign valid_out    = idEx_q.valid;

endmodule
